// File: rtl/sb_rx_pkg.sv
// sb_rx_pkg: shared state encoding and header field positions for the sideband receive path.
package sb_rx_pkg;
  typedef enum logic [1:0] {HDR, DATA, OUT} state_t;
  localparam int WIDTH_DEF        = 64;
  localparam int HAS_DATA_BIT_DEF = 5;
  localparam int CP_BIT           = 63;
  localparam int DP_BIT           = 62;
endpackage

// File: rtl/sb_rx_pkt_ctrl_if.sv
// sb_rx_pkt_ctrl_if: word stream from the deserializer and packet stream to the message layer.
interface sb_rx_pkt_ctrl_if
  import sb_rx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic [WIDTH-1:0] in_word;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] pkt_hdr;
  logic [WIDTH-1:0] pkt_data;
  logic             pkt_has_data;
  logic             pkt_valid;
  logic             pkt_ready;
  modport master (
    output in_word, in_valid, pkt_ready,
    input  in_ready, pkt_hdr, pkt_data, pkt_has_data, pkt_valid
  );
  modport slave (
    input  in_word, in_valid, pkt_ready,
    output in_ready, pkt_hdr, pkt_data, pkt_has_data, pkt_valid
  );
endinterface

// File: rtl/sb_rx_err_counter.sv
// sb_rx_err_counter: one-cycle error pulse plus saturating error count, both registered from inc.
module sb_rx_err_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic             pulse,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pulse <= 1'b0;
      cnt   <= '0;
    end else begin
      pulse <= inc;
      if (inc && !(&cnt)) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/sb_rx_pkt_ctrl.sv
// sb_rx_pkt_ctrl: assembles header(+data) words into packets with data-phase timeout.
// Define SB_RX_PARITY_CHECK_EN to drop packets with bad control or data parity.
module sb_rx_pkt_ctrl
  import sb_rx_pkg::*;
#(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int HAS_DATA_BIT = HAS_DATA_BIT_DEF,
  parameter int TIMEOUT      = 1024,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  sb_rx_pkt_ctrl_if.slave  bus,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t           state, state_nxt;
  logic [TW-1:0]    tcnt;
  logic [WIDTH-1:0] word;
  logic             xfer, timed_out, cp_bad, dp_bad, drop;
  assign word          = bus.in_word;
  assign xfer          = bus.in_valid && bus.in_ready;
  assign timed_out     = tcnt == TW'(TIMEOUT - 1);
  assign bus.pkt_valid = state == OUT;
  assign bus.in_ready  = rst_n && ((state == HDR && enable) || state == DATA);
`ifdef SB_RX_PARITY_CHECK_EN
  assign cp_bad = word[CP_BIT] ^ (^word[CP_BIT-1:0]);
  assign dp_bad = bus.pkt_hdr[DP_BIT] ^ (^word);
`else
  assign cp_bad = 1'b0;
  assign dp_bad = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= HDR;
    else state <= state_nxt;
  // A data word arriving in the timeout cycle takes priority over the drop.
  always_comb begin
    state_nxt = state;
    drop      = 1'b0;
    case (state)
      HDR: if (xfer) begin
        drop      = cp_bad;
        state_nxt = cp_bad ? HDR : word[HAS_DATA_BIT] ? DATA : OUT;
      end
      DATA: if (xfer || timed_out) begin
        drop      = xfer ? dp_bad : 1'b1;
        state_nxt = (xfer && !dp_bad) ? OUT : HDR;
      end
      OUT: if (bus.pkt_ready) state_nxt = HDR;
      default: state_nxt = HDR;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tcnt             <= '0;
      bus.pkt_hdr      <= '0;
      bus.pkt_data     <= '0;
      bus.pkt_has_data <= 1'b0;
    end else if (state == HDR && xfer) begin
      tcnt             <= '0;
      bus.pkt_hdr      <= word;
      bus.pkt_data     <= '0;
      bus.pkt_has_data <= 1'b0;
    end else if (state == DATA) begin
      tcnt <= tcnt + 1'b1;
      if (xfer) begin
        bus.pkt_data     <= word;
        bus.pkt_has_data <= 1'b1;
      end
    end
  sb_rx_err_counter #(.CNT_W(CNT_W)) u_err (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drop),
    .pulse (err_pulse),
    .cnt   (err_cnt)
  );
endmodule

// File: tb/tb_sb_rx_pkt_ctrl.sv
// tb_sb_rx_pkt_ctrl: directed vector table plus timeout, saturation and reset sequences.
module tb_sb_rx_pkt_ctrl;
  localparam int TO = 16;
  localparam int CW = 2;
  localparam logic [63:0] D = 64'hDEAD_BEEF_CAFE_F00D;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b1;
  logic          err_pulse;
  logic [CW-1:0] err_cnt;
  int            nvec = 0;
  int            nbad = 0;
  sb_rx_pkt_ctrl_if #(.WIDTH(64)) bus ();
  sb_rx_pkt_ctrl #(.WIDTH(64), .HAS_DATA_BIT(5), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .bus       (bus),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt)
  );
  always #5 clk = ~clk;
  typedef struct {
    string         name;
    logic          iv, en;
    logic [63:0]   w;
    logic          pr, rdy, pv, hd;
    logic [63:0]   hdr, data;
    logic          ep;
    logic [CW-1:0] ec;
  } vec_t;
  function automatic logic [63:0] hdr_of(input logic [63:0] h, input logic [63:0] d);
    logic [63:0] r = h;
`ifdef SB_RX_PARITY_CHECK_EN
    r[62] = ^d;
    r[63] = ^r[62:0];
`endif
    return r;
  endfunction
  function automatic vec_t mk(input string n, input logic iv, input logic en, input logic [63:0] w,
                              input logic pr, input logic rdy, input logic pv, input logic hd,
                              input logic [63:0] hdr, input logic [63:0] data, input logic ep,
                              input logic [CW-1:0] ec);
    vec_t v;
    v.name = n; v.iv = iv; v.en = en; v.w = w; v.pr = pr; v.rdy = rdy; v.pv = pv; v.hd = hd;
    v.hdr = hdr; v.data = data; v.ep = ep; v.ec = ec;
    return v;
  endfunction
  // in_ready is sampled before the edge, everything else one step after it.
  task automatic apply(input vec_t v);
    logic r;
    bus.in_valid = v.iv; enable = v.en; bus.in_word = v.w; bus.pkt_ready = v.pr;
    #1 r = bus.in_ready;
    @(posedge clk); #1;
    nvec++;
    if ({r, bus.pkt_valid, bus.pkt_has_data, bus.pkt_hdr, bus.pkt_data, err_pulse, err_cnt} !==
        {v.rdy, v.pv, v.hd, v.hdr, v.data, v.ep, v.ec}) begin
      nbad++;
      $display("FAIL %s: got rdy=%b pv=%b hd=%b hdr=%h data=%h ep=%b ec=%0d, want rdy=%b pv=%b hd=%b hdr=%h data=%h ep=%b ec=%0d",
               v.name, r, bus.pkt_valid, bus.pkt_has_data, bus.pkt_hdr, bus.pkt_data, err_pulse, err_cnt,
               v.rdy, v.pv, v.hd, v.hdr, v.data, v.ep, v.ec);
    end
  endtask
  task automatic check_reset(input string n);
    nvec++;
    if ({bus.in_ready, bus.pkt_valid, bus.pkt_has_data, bus.pkt_hdr, bus.pkt_data, err_pulse, err_cnt} !== '0) begin
      nbad++;
      $display("FAIL %s: got rdy=%b pv=%b hd=%b hdr=%h data=%h ep=%b ec=%0d, want all zero",
               n, bus.in_ready, bus.pkt_valid, bus.pkt_has_data, bus.pkt_hdr, bus.pkt_data, err_pulse, err_cnt);
    end
  endtask
  initial begin
    logic [63:0] h0, hd;
    logic [CW-1:0] ec;
    vec_t tbl[$];
    h0 = hdr_of(64'h1, 64'h0);
    hd = hdr_of(64'h21, D);
    tbl.push_back(mk("hdr_only",      1, 1, h0, 1, 1, 1, 0, h0, 0, 0, 0));
    tbl.push_back(mk("hdr_only_done", 0, 1, 0,  1, 0, 0, 0, h0, 0, 0, 0));
    tbl.push_back(mk("data_hdr",      1, 1, hd, 0, 1, 0, 0, hd, 0, 0, 0));
    tbl.push_back(mk("data_word",     1, 1, D,  0, 1, 1, 1, hd, D, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk("data_hold",   1, 1, 64'h5555, 0, 0, 1, 1, hd, D, 0, 0));
    tbl.push_back(mk("data_done",     0, 1, 0,  1, 0, 0, 1, hd, D, 0, 0));
    tbl.push_back(mk("en_hdr",        1, 1, hd, 1, 1, 0, 0, hd, 0, 0, 0));
    tbl.push_back(mk("en0_data",      1, 0, D,  0, 1, 1, 1, hd, D, 0, 0));
    tbl.push_back(mk("en0_out",       0, 0, 0,  1, 0, 0, 1, hd, D, 0, 0));
    tbl.push_back(mk("en0_blocked",   1, 0, h0, 1, 0, 0, 1, hd, D, 0, 0));
    tbl.push_back(mk("en0_blocked2",  1, 0, h0, 1, 0, 0, 1, hd, D, 0, 0));
    tbl.push_back(mk("en1_hdr",       1, 1, h0, 0, 1, 1, 0, h0, 0, 0, 0));
    tbl.push_back(mk("en1_done",      0, 1, 0,  1, 0, 0, 0, h0, 0, 0, 0));
    bus.in_valid = 1'b0; bus.in_word = '0; bus.pkt_ready = 1'b0;
    #1 check_reset("reset_state");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);
    apply(mk("to_edge_hdr", 1, 1, hd, 1, 1, 0, 0, hd, 0, 0, 0));
    for (int i = 1; i < TO; i++) apply(mk("to_edge_wait", 0, 1, 0, 1, 1, 0, 0, hd, 0, 0, 0));
    apply(mk("to_edge_data", 1, 1, D, 1, 1, 1, 1, hd, D, 0, 0));
    apply(mk("to_edge_done", 0, 1, 0, 1, 0, 0, 1, hd, D, 0, 0));
    ec = 0;
    for (int d = 1; d <= 5; d++) begin
      apply(mk("drop_hdr", 1, 1, hd, 1, 1, 0, 0, hd, 0, 0, ec));
      for (int i = 1; i < TO; i++) apply(mk("drop_wait", 0, 1, 0, 1, 1, 0, 0, hd, 0, 0, ec));
      ec = (d > 3) ? CW'(3) : CW'(d);
      apply(mk("drop_timeout", 0, 1, 0, 1, 1, 0, 0, hd, 0, 1, ec));
    end
    apply(mk("after_drop", 0, 1, 0, 1, 1, 0, 0, hd, 0, 0, 3));
    apply(mk("rst_hdr", 1, 1, hd, 1, 1, 0, 0, hd, 0, 0, 3));
    rst_n = 1'b0; bus.in_valid = 1'b0;
    #1 check_reset("rst_mid_data");
    @(posedge clk);
    #1 rst_n = 1'b1;
    apply(mk("rst_next_hdr",  1, 1, h0, 0, 1, 1, 0, h0, 0, 0, 0));
    apply(mk("rst_next_done", 0, 1, 0,  1, 0, 0, 0, h0, 0, 0, 0));
`ifdef SB_RX_PARITY_CHECK_EN
    apply(mk("cp_bad", 1, 1, h0 ^ {1'b1, 63'h0}, 1, 1, 0, 0, h0 ^ {1'b1, 63'h0}, 0, 1, 1));
    apply(mk("dp_hdr", 1, 1, hd, 1, 1, 0, 0, hd, 0, 0, 1));
    apply(mk("dp_bad", 1, 1, D ^ 64'h1, 1, 1, 0, 1, hd, D ^ 64'h1, 1, 2));
    apply(mk("dp_after", 0, 1, 0, 1, 1, 0, 1, hd, D ^ 64'h1, 0, 2));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
